// File: rtl/lab06_if_pkg.sv
// lab06_if_pkg: shared widths, FSM state and result type for the lab06_4 interface
package lab06_if_pkg;
  localparam int NUMBER_W = 4;
  localparam int MODE_W = 2;
  localparam int RESULT_W = 6;
  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;
  typedef logic signed [RESULT_W-1:0] result_t;
endpackage

// File: rtl/lab06_nibble_shifter.sv
// lab06_nibble_shifter: parallel-load operand register that shifts out one nibble per beat
// Zero fill on shift leaves the low nibble at 0 once every loaded beat has gone out.
module lab06_nibble_shifter
  import lab06_if_pkg::*;
#(
  parameter int NUM_BEATS = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load_i,
  input  logic                          shift_i,
  input  logic [NUMBER_W*NUM_BEATS-1:0] data_i,
  output logic [NUMBER_W-1:0]           nibble_o,
  output logic                          last_beat_o
);
  logic [NUMBER_W*NUM_BEATS-1:0] sh_q, sh_d;
  logic [3:0] cnt_q, cnt_d;
  assign nibble_o = sh_q[NUMBER_W-1:0];
  assign last_beat_o = cnt_q == 4'(NUM_BEATS - 1);
  always_comb begin
    sh_d = load_i ? data_i : shift_i ? sh_q >> NUMBER_W : sh_q;
    cnt_d = (load_i || (shift_i && last_beat_o)) ? '0 : shift_i ? cnt_q + 4'd1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sh_q <= '0;
      cnt_q <= '0;
    end else begin
      sh_q <= sh_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/lab06_stim_driver.sv
// lab06_stim_driver: initiator that serializes one operand vector and waits for the result
// Every output is a flop; strobes are derived from the next state so they line up with it.
module lab06_stim_driver
  import lab06_if_pkg::*;
#(
  parameter int NUM_BEATS = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [MODE_W-1:0]             cfg_mode,
  input  logic [NUMBER_W*NUM_BEATS-1:0] cfg_numbers,
  output logic                          busy,
  output logic                          done,
  output logic signed [RESULT_W-1:0]    result,
  output logic                          timeout_err,
  output logic                          in_valid,
  output logic [NUMBER_W-1:0]           in_number,
  output logic [MODE_W-1:0]             mode,
  input  logic                          out_valid,
  input  logic signed [RESULT_W-1:0]    out_result
);
  state_t state_q, state_d;
  logic [7:0] tmo_q, tmo_d;
  result_t result_q, result_d;
  logic terr_q, terr_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic busy_q, done_q, in_valid_q;
  logic accept, last_beat;
  assign accept = state_q == IDLE && start;
  lab06_nibble_shifter #(.NUM_BEATS(NUM_BEATS)) u_shifter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (accept),
    .shift_i    (state_q == SEND),
    .data_i     (cfg_numbers),
    .nibble_o   (in_number),
    .last_beat_o(last_beat)
  );
  always_comb begin
    state_d = state_q;
    tmo_d = tmo_q;
    result_d = result_q;
    terr_d = terr_q;
    mode_d = accept ? cfg_mode : '0;
    unique case (state_q)
      IDLE: if (start) begin
        state_d = SEND;
        terr_d = 1'b0;
      end
      SEND: begin
        tmo_d = '0;
        if (last_beat) state_d = WAIT;
      end
      WAIT: if (out_valid) begin
        state_d = DONE;
        result_d = out_result;
        terr_d = 1'b0;
      end else if (tmo_q == 8'(TIMEOUT - 1)) begin
        state_d = DONE;
        result_d = '0;
        terr_d = 1'b1;
      end else begin
        tmo_d = tmo_q + 8'd1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      tmo_q <= '0;
      result_q <= '0;
      terr_q <= 1'b0;
      mode_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      in_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q <= tmo_d;
      result_q <= result_d;
      terr_q <= terr_d;
      mode_q <= mode_d;
      busy_q <= state_d == SEND || state_d == WAIT;
      done_q <= state_d == DONE;
      in_valid_q <= state_d == SEND;
    end
  assign busy = busy_q;
  assign done = done_q;
  assign result = result_q;
  assign timeout_err = terr_q;
  assign in_valid = in_valid_q;
  assign mode = mode_q;
endmodule

// File: tb/tb_lab06_stim_driver.sv
// tb_lab06_stim_driver: scoreboard bench; beats and completions are queued at start and popped as they appear
module tb_lab06_stim_driver;
  localparam int NB = 4;
  localparam int TO = 16;
  logic clk = 0, rst_n = 0, start = 0, out_valid = 0;
  logic [1:0] cfg_mode = 0;
  logic [15:0] cfg_numbers = 0;
  logic [5:0] out_result = 0;
  logic busy, done, timeout_err, in_valid;
  logic [5:0] result;
  logic [3:0] in_number;
  logic [1:0] mode;
  int cyc = 0, ts = 0, total = 0, bad = 0;
  typedef struct {int at; logic [3:0] num; logic [1:0] md;} beat_t;
  typedef struct {int at; logic [5:0] res; logic terr;} resp_t;
  beat_t beat_q[$];
  resp_t res_q[$];
  beat_t b;
  resp_t r;
  lab06_stim_driver #(.NUM_BEATS(NB), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_mode(cfg_mode), .cfg_numbers(cfg_numbers),
    .busy(busy), .done(done), .result(result), .timeout_err(timeout_err), .in_valid(in_valid),
    .in_number(in_number), .mode(mode), .out_valid(out_valid), .out_result(out_result)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [1:0] m, input logic [15:0] n, input int c, input logic [5:0] res, input int pre);
    start = 1;
    cfg_mode = m;
    cfg_numbers = n;
    repeat (pre + 1) @(posedge clk);
    #1 ts = cyc;
    start = 0;
    for (int k = 0; k < NB; k++) beat_q.push_back('{ts + k, n[4*k +: 4], k == 0 ? m : 2'b00});
    if (c < 0) res_q.push_back('{ts + NB + TO, 6'd0, 1'b1});
    else res_q.push_back('{ts + c, res, 1'b0});
  endtask
  task automatic pulse_at(input int at, input logic [5:0] v);
    if (at > cyc) tick(at - cyc);
    out_valid = 1;
    out_result = v;
    tick(1);
    out_valid = 0;
  endtask
  task automatic wait_done();
    for (int i = 0; i < 100 && res_q.size() != 0; i++) tick(1);
    check("wait_done", res_q.size(), 0);
  endtask
  always @(negedge clk) if (rst_n) begin
    if (in_valid) begin
      if (beat_q.size() == 0) check("unexp_beat", in_valid, 0);
      else begin
        b = beat_q.pop_front();
        check("beat_cyc", cyc, b.at);
        check("beat_num", in_number, b.num);
        check("beat_mode", mode, b.md);
      end
    end
    if (done) begin
      if (res_q.size() == 0) check("unexp_done", done, 0);
      else begin
        r = res_q.pop_front();
        check("done_cyc", cyc, r.at);
        check("result", result, r.res);
        check("timeout_err", timeout_err, r.terr);
        check("busy_at_done", busy, 0);
      end
    end
  end
  initial begin
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_terr", timeout_err, 0);
    check("rst_in_valid", in_valid, 0);
    check("rst_in_number", in_number, 0);
    check("rst_mode", mode, 0);
    check("rst_result", result, 0);
    tick(2);
    rst_n = 1;
    tick(1);
    send(2'b01, 16'h4321, 7, 6'b111010, 0);
    pulse_at(ts + 6, 6'b111010);
    wait_done();
    tick(1);
    send(2'b10, 16'h1111, -1, 6'd0, 0);
    wait_done();
    tick(2);
    check("terr_hold", timeout_err, 1);
    check("terr_res", result, 0);
    send(2'b11, 16'h5a5a, 6, 6'h15, 0);
    check("terr_clr", timeout_err, 0);
    pulse_at(ts + 5, 6'h15);
    wait_done();
    tick(1);
    send(2'b01, 16'h4321, 7, 6'h3a, 0);
    tick(1);
    start = 1;
    cfg_numbers = 16'hFFFF;
    cfg_mode = 2'b11;
    tick(1);
    start = 0;
    pulse_at(ts + 6, 6'h3a);
    wait_done();
    tick(NB + 2);
    send(2'b10, 16'h9876, 8, 6'd31, 0);
    pulse_at(ts + 1, 6'd5);
    pulse_at(ts + 7, 6'd31);
    wait_done();
    pulse_at(cyc + 1, 6'd5);
    tick(1);
    check("idle_ov_result", result, 31);
    send(2'b01, 16'hABCD, 7, 6'd0, 0);
    tick(1);
    @(negedge clk);
    #1 rst_n = 0;
    #1;
    check("mid_rst_in_valid", in_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_number", in_number, 0);
    check("mid_rst_mode", mode, 0);
    check("mid_rst_result", result, 0);
    check("mid_rst_beats_left", beat_q.size(), 2);
    beat_q.delete();
    res_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1;
    tick(2);
    send(2'b01, 16'h4321, 7, 6'h3a, 0);
    pulse_at(ts + 6, 6'h3a);
    wait_done();
    tick(1);
    send(2'b11, 16'h0f0f, 6, 6'h20, 0);
    pulse_at(ts + 5, 6'h20);
    send(2'b00, 16'h1234, 6, 6'h01, 1);
    pulse_at(ts + 5, 6'h01);
    wait_done();
    tick(NB + 2);
    check("beats_left", beat_q.size(), 0);
    check("resp_left", res_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
